// File: rtl/axi_burst_tracker.sv
// Passive AXI3 burst monitor: follows one write and one read burst at a time and
// emits a one-cycle completion record (first/last byte address, error flags, count).

module axi_burst_tracker_chan #(
  parameter int AW       = 32,
  parameter int SW       = 8,
  parameter bit IS_WRITE = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          a_valid_i,
  input  logic          a_ready_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [3:0]    a_len_i,
  input  logic [2:0]    a_size_i,
  input  logic          d_valid_i,
  input  logic          d_ready_i,
  input  logic          d_last_i,
  input  logic [SW-1:0] d_strb_i,
  output logic          done_o,
  output logic [AW-1:0] start_o,
  output logic [AW-1:0] end_o,
  output logic [3:0]    err_o,
  output logic [15:0]   cnt_o,
  output logic          overlap_o,
  output logic          busy_o
);

  // Handshake: a transfer happens on any rising edge where valid & ready are both high.
  typedef enum logic {S_IDLE = 1'b0, S_DATA = 1'b1} state_t;

  localparam logic [2:0] MAX_SIZE = (SW == 8) ? 3'd3 : 3'd2;

  state_t        state_q, state_d;
  logic [3:0]    beat_q, beat_d;
  logic [3:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] first_q, first_d;
  logic          serr_q, serr_d;

  logic          done_q, done_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW-1:0] end_q, end_d;
  logic [3:0]    err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          a_hs, d_hs, start_new, beat_act, complete, hit_len;
  logic          early_last, missing_last, size_err;
  logic [AW-1:0] eff_addr, size_mask, burst_bytes, end_addr;
  logic [3:0]    eff_len, eff_beat;
  logic [2:0]    eff_size, size_c;
  logic [2:0]    lo_idx, off;
  logic          lo_found;
  logic [AW-1:0] beat0_start, cur_start;
  logic          beat0_serr, cur_serr;

  assign a_hs      = a_valid_i & a_ready_i;
  assign d_hs      = d_valid_i & d_ready_i;
  assign start_new = (state_q == S_IDLE) & a_hs;
  // A beat in the address-handshake cycle belongs to the burst being opened (beat 0).
  assign beat_act  = d_hs & ((state_q == S_DATA) | start_new);

  assign eff_addr = start_new ? a_addr_i : addr_q;
  assign eff_len  = start_new ? a_len_i  : len_q;
  assign eff_size = start_new ? a_size_i : size_q;
  assign eff_beat = start_new ? 4'd0     : beat_q;

  assign hit_len      = (eff_beat == eff_len);
  assign complete     = beat_act & (hit_len | d_last_i);
  assign early_last   = d_last_i & ~hit_len;
  assign missing_last = hit_len & ~d_last_i;

  assign size_err    = (eff_size > MAX_SIZE);
  assign size_c      = size_err ? MAX_SIZE : eff_size;
  assign size_mask   = (AW'(1) << size_c) - AW'(1);
  assign burst_bytes = AW'({1'b0, eff_len} + 5'd1) << size_c;
  assign end_addr    = (eff_addr & ~size_mask) + burst_bytes - AW'(1);

  always_comb begin
    lo_idx   = 3'd0;
    lo_found = 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (!lo_found && d_strb_i[i]) begin
        lo_idx   = 3'(i);
        lo_found = 1'b1;
      end
    end
  end

  // On a 32-bit bus the strobe only resolves the low two bits; bit 2 comes from the address.
  always_comb begin
    if (!lo_found)    off = eff_addr[2:0];
    else if (SW == 8) off = lo_idx;
    else              off = {eff_addr[2], lo_idx[1:0]};
  end

  assign beat0_start = IS_WRITE ? {eff_addr[AW-1:3], off} : eff_addr;
  assign beat0_serr  = IS_WRITE & ~lo_found;
  assign cur_start   = (eff_beat == 4'd0) ? beat0_start : first_q;
  assign cur_serr    = (eff_beat == 4'd0) ? beat0_serr  : serr_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    len_d     = len_q;
    size_d    = size_q;
    addr_d    = addr_q;
    first_d   = first_q;
    serr_d    = serr_q;
    overlap_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (a_hs) begin
          addr_d  = a_addr_i;
          len_d   = a_len_i;
          size_d  = a_size_i;
          beat_d  = 4'd0;
          state_d = S_DATA;
          if (complete) begin
            state_d = S_IDLE;
          end else if (beat_act) begin
            beat_d  = 4'd1;
            first_d = cur_start;
            serr_d  = cur_serr;
          end
        end
      end
      S_DATA: begin
        if (complete) begin
          state_d = S_IDLE;
          if (a_hs) begin
            addr_d  = a_addr_i;
            len_d   = a_len_i;
            size_d  = a_size_i;
            beat_d  = 4'd0;
            state_d = S_DATA;
          end
        end else begin
          if (beat_act) begin
            beat_d  = beat_q + 4'd1;
            first_d = cur_start;
            serr_d  = cur_serr;
          end
          overlap_o = a_hs;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d  = complete;
    start_d = start_q;
    end_d   = end_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (complete) begin
      start_d = cur_start;
      end_d   = end_addr;
      err_d   = {size_err, cur_serr, early_last, missing_last};
      cnt_d   = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      first_q <= '0;
      serr_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      serr_q  <= serr_d;
      done_q  <= done_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_o  = done_q;
  assign start_o = start_q;
  assign end_o   = end_q;
  assign err_o   = err_q;
  assign cnt_o   = cnt_q;
  assign busy_o  = (state_q == S_DATA);

endmodule

module axi_burst_tracker #(
  parameter  int AXI_AWIDTH = 32,
  parameter  int AXI_DWIDTH = 64,
  localparam int AXI_WRSTB  = AXI_DWIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  AWVALID,
  input  logic                  AWREADY,
  input  logic [AXI_AWIDTH-1:0] AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  WVALID,
  input  logic                  WREADY,
  input  logic                  WLAST,
  input  logic [AXI_WRSTB-1:0]  WSTRB,
  input  logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [AXI_AWIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  RLAST,
  output logic                  WR_DONE,
  output logic [AXI_AWIDTH-1:0] WR_START,
  output logic [AXI_AWIDTH-1:0] WR_END,
  output logic [3:0]            WR_ERR,
  output logic                  RD_DONE,
  output logic [AXI_AWIDTH-1:0] RD_START,
  output logic [AXI_AWIDTH-1:0] RD_END,
  output logic [3:0]            RD_ERR,
  output logic                  OVERLAP,
  output logic [15:0]           WR_CNT,
  output logic [15:0]           RD_CNT,
  output logic                  WR_STATE_DBG,
  output logic                  RD_STATE_DBG
);

  logic wr_ov, rd_ov;
  logic overlap_q, overlap_d;

  axi_burst_tracker_chan #(
    .AW       (AXI_AWIDTH),
    .SW       (AXI_WRSTB),
    .IS_WRITE (1'b1)
  ) u_wr (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .a_valid_i (AWVALID),
    .a_ready_i (AWREADY),
    .a_addr_i  (AWADDR),
    .a_len_i   (AWLEN),
    .a_size_i  (AWSIZE),
    .d_valid_i (WVALID),
    .d_ready_i (WREADY),
    .d_last_i  (WLAST),
    .d_strb_i  (WSTRB),
    .done_o    (WR_DONE),
    .start_o   (WR_START),
    .end_o     (WR_END),
    .err_o     (WR_ERR),
    .cnt_o     (WR_CNT),
    .overlap_o (wr_ov),
    .busy_o    (WR_STATE_DBG)
  );

  // The read channel has no strobes; an all-ones strobe keeps the shared logic inert.
  axi_burst_tracker_chan #(
    .AW       (AXI_AWIDTH),
    .SW       (AXI_WRSTB),
    .IS_WRITE (1'b0)
  ) u_rd (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .a_valid_i (ARVALID),
    .a_ready_i (ARREADY),
    .a_addr_i  (ARADDR),
    .a_len_i   (ARLEN),
    .a_size_i  (ARSIZE),
    .d_valid_i (RVALID),
    .d_ready_i (RREADY),
    .d_last_i  (RLAST),
    .d_strb_i  ({AXI_WRSTB{1'b1}}),
    .done_o    (RD_DONE),
    .start_o   (RD_START),
    .end_o     (RD_END),
    .err_o     (RD_ERR),
    .cnt_o     (RD_CNT),
    .overlap_o (rd_ov),
    .busy_o    (RD_STATE_DBG)
  );

  assign overlap_d = overlap_q | wr_ov | rd_ov;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) overlap_q <= 1'b0;
    else          overlap_q <= overlap_d;
  end

  assign OVERLAP = overlap_q;

endmodule
